aibnd_red_lanemux_seq: RTL

AIBND_RED_LANEMUX_SEQ -- requirements
Module: aibnd_red_lanemux_seq

---
 rtl/aibnd_red_lanemux_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aibnd_red_lanemux_seq.sv
// Redundancy lane mux with a blank/load/settle switching sequence.
// Ports: clk, rstb (sync active-low), din[(NCH+1)*W] (lane NCH = spare),
//   sel_req/sel_new (mask change request), dout[NCH*W] (registered lanes),
//   sel_cur (applied mask), busy, sel_ack, sel_err, vccl/vssl supplies.
module aibnd_red_lanemux_seq #(
    parameter int NCH  = 4,
    parameter int W    = 1,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [(NCH+1)*W-1:0] din,
    input  logic                 sel_req,
    input  logic [NCH-1:0]       sel_new,
    output logic [NCH*W-1:0]     dout,
    output logic [NCH-1:0]       sel_cur,
    output logic                 busy,
    output logic                 sel_ack,
    output logic                 sel_err,
    input  logic                 vccl_aibnd,
    input  logic                 vssl_aibnd
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LD = CW'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BLANK, S_LOAD, S_SETTLE, S_ACK
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [NCH-1:0]   r_pend;
    logic [NCH-1:0]   r_sel_cur;
    logic [NCH*W-1:0] r_dout;
    logic             r_armed;
    logic             r_err;
    logic             w_legal;
    logic             w_accept;
    logic             w_reject;
    logic             w_blank_nxt;
    logic             w_supply_tie;
    logic [NCH*W-1:0] w_steer;

    // Supplies stay connected but only feed an always-true term.
    assign w_supply_tie = vccl_aibnd | ~vccl_aibnd | vssl_aibnd;

    // Thermometer: a set bit must have every higher bit set.
    always_comb begin
        w_legal = 1'b1;
        for (int i = 0; i < NCH - 1; i++) begin
            if (sel_new[i] && !sel_new[i+1]) w_legal = 1'b0;
        end
    end

    always_comb begin
        w_steer = '0;
        for (int i = 0; i < NCH; i++) begin
            w_steer[i*W +: W] = r_sel_cur[i] ? din[(i+1)*W +: W]
                                             : din[i*W +: W];
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_accept  = 1'b0;
        w_reject  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // r_armed drops requests seen in the first cycle out of reset
                if (sel_req && r_armed) begin
                    if (w_legal) begin
                        w_nxt     = S_BLANK;
                        w_cnt_nxt = LD;
                        w_accept  = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_BLANK: begin
                if (r_cnt == '0) begin
                    w_nxt     = S_LOAD;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_LOAD: begin
                w_nxt     = S_SETTLE;
                w_cnt_nxt = LD;
            end
            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_nxt     = S_ACK;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACK: begin
                w_nxt     = S_IDLE;
                w_cnt_nxt = '0;
            end
            default: begin
                w_nxt     = S_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // dout is blanked on the state being entered so the zero window
    // lines up with BLANK/LOAD/SETTLE and ACK already shows new steering.
    assign w_blank_nxt = (w_nxt == S_BLANK) || (w_nxt == S_LOAD) ||
                         (w_nxt == S_SETTLE);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_sel_cur <= '0;
            r_dout    <= '0;
            r_armed   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= w_supply_tie;
            r_err   <= w_reject;
            if (w_accept) r_pend <= sel_new;
            if (r_state == S_LOAD) r_sel_cur <= r_pend;
            r_dout <= w_blank_nxt ? '0 : w_steer;
        end
    end

    assign dout    = r_dout;
    assign sel_cur = r_sel_cur;
    assign busy    = (r_state != S_IDLE);
    assign sel_ack = (r_state == S_ACK);
    assign sel_err = r_err;

endmodule
